// File: rtl/load_store_unit_if.sv
// Bundle of core request/response and data-memory strobe signals for load_store_unit.
// Ports: master = core + memory side (drives req_*, mem_read_data); slave = the LSU.
interface load_store_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic                     req_byte;
    logic                     req_signed;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     resp_valid;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_error;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic                     mem_we;
    logic                     mem_re;
    logic                     mem_be;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    modport master (
        output req_valid, req_write, req_byte, req_signed,
        output req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data, mem_we, mem_re, mem_be
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed,
        input  req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data, mem_we, mem_re, mem_be
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end for data_memory: one request at a time, alignment/range
// check, memory strobes, byte load extension. Ports: clk, rst (async active-low),
// bus (load_store_unit_if.slave). Optional LSU_STATS_EN adds stat_loads/stores/errors.
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef LSU_STATS_EN
    output logic [15:0]            stat_loads,
    output logic [15:0]            stat_stores,
    output logic [15:0]            stat_errors,
`endif
    load_store_unit_if.slave       bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LP_WLIM = ADDRESS_WIDTH'(MEM_SIZE - 4);
    localparam logic [ADDRESS_WIDTH-1:0] LP_BLIM = ADDRESS_WIDTH'(MEM_SIZE - 1);

    state_t r_state;
    logic   r_write;
    logic   r_byte;
    logic   r_signed;

    logic                  w_fail;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load;

    always_comb begin
        w_fail = 1'b0;
        if (bus.req_byte) begin
            w_fail = bus.req_addr > LP_BLIM;
        end else begin
            w_fail = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr > LP_WLIM);
        end
    end

    assign w_wdata = bus.req_byte
        ? {{(DATA_WIDTH-8){1'b0}}, bus.req_wdata[7:0]}
        : bus.req_wdata;

    // Byte loads keep only the low byte; upper bits come from the extension.
    always_comb begin
        w_load = bus.mem_read_data;
        if (r_byte) begin
            w_load = {{(DATA_WIDTH-8){r_signed & bus.mem_read_data[7]}},
                      bus.mem_read_data[7:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= S_IDLE;
            r_write            <= 1'b0;
            r_byte             <= 1'b0;
            r_signed           <= 1'b0;
            bus.req_ready      <= 1'b1;
            bus.resp_valid     <= 1'b0;
            bus.resp_error     <= 1'b0;
            bus.resp_rdata     <= '0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_we         <= 1'b0;
            bus.mem_re         <= 1'b0;
            bus.mem_be         <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write       <= bus.req_write;
                        r_byte        <= bus.req_byte;
                        r_signed      <= bus.req_signed;
                        bus.req_ready <= 1'b0;
                        if (w_fail) begin
                            r_state        <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                        end else begin
                            r_state            <= S_ACCESS;
                            bus.mem_address    <= bus.req_addr;
                            bus.mem_be         <= bus.req_byte;
                            bus.mem_we         <= bus.req_write;
                            bus.mem_re         <= ~bus.req_write;
                            bus.mem_write_data <= bus.req_write ? w_wdata : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_write) begin
                        r_state            <= S_RESP;
                        bus.resp_valid     <= 1'b1;
                        bus.mem_address    <= '0;
                        bus.mem_write_data <= '0;
                        bus.mem_we         <= 1'b0;
                        bus.mem_be         <= 1'b0;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state         <= S_RESP;
                    bus.resp_valid  <= 1'b1;
                    bus.resp_rdata  <= w_load;
                    bus.mem_address <= '0;
                    bus.mem_re      <= 1'b0;
                    bus.mem_be      <= 1'b0;
                end
                S_RESP: begin
                    r_state        <= S_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_error <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (r_state == S_RESP) begin
            if (bus.resp_error) begin
                if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
            end else if (r_write) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural memory model.
// Drives/samples on the falling clock edge; reports CHECKS/ERRORS summary.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_init = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] tmem [1024];
    logic [7:0] ref_mem [1024];

`ifdef LSU_STATS_EN
    logic [15:0] sl, ss, se;
`endif

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LSU_STATS_EN
        .stat_loads  (sl),
        .stat_stores (ss),
        .stat_errors (se),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for data_memory: little-endian bytes, read data one cycle after re.
    // Byte reads return junk in the upper bits so the LSU must extend.
    always @(posedge clk) begin
        logic [31:0] g;
        logic [9:0]  a;
        g = $urandom;
        a = bus.mem_address[9:0];
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tmem[i] <= 8'(i * 37) ^ 8'h5A;
        end else begin
            if (bus.mem_we) begin
                tmem[a] <= bus.mem_write_data[7:0];
                if (!bus.mem_be) begin
                    tmem[a + 10'd1] <= bus.mem_write_data[15:8];
                    tmem[a + 10'd2] <= bus.mem_write_data[23:16];
                    tmem[a + 10'd3] <= bus.mem_write_data[31:24];
                end
            end
            if (bus.mem_re) begin
                bus.mem_read_data <= bus.mem_be ? {g[31:8], tmem[a]}
                    : {tmem[a + 10'd3], tmem[a + 10'd2], tmem[a + 10'd1], tmem[a]};
            end
        end
    end

    function automatic logic exp_fail(input logic b, input logic [31:0] a);
        if (b) return a > 32'd1023;
        return (a % 4 != 0) || (a > 32'd1020);
    endfunction

    function automatic logic [31:0] ref_load(input logic b, input logic s,
                                             input logic [31:0] a);
        int v;
        if (b) begin
            v = int'(ref_mem[a[9:0]]);
            if (s && v >= 128) v = v - 256;
            return 32'(v);
        end
        return {ref_mem[a[9:0] + 10'd3], ref_mem[a[9:0] + 10'd2],
                ref_mem[a[9:0] + 10'd1], ref_mem[a[9:0]]};
    endfunction

    task automatic ref_store(input logic b, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < (b ? 1 : 4); i++) ref_mem[a[9:0] + 10'(i)] = d[8*i +: 8];
    endtask

    // Drives one request from an IDLE falling edge and records what the DUT does
    // cycle by cycle (k = cycles after the accept edge). Returns at the first
    // falling edge where the unit is ready again after its response.
    task automatic issue(input logic w, input logic b, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         output int rk, output logic [31:0] rdat, output logic rerr,
                         output int wem, output int rem, output int rdym, output int nresp,
                         output logic [31:0] oaddr, output logic [31:0] owd,
                         output logic obe);
        rk = 0; rdat = '0; rerr = 1'b0; wem = 0; rem = 0; rdym = 0; nresp = 0;
        oaddr = '0; owd = '0; obe = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_write  = ~w;
        bus.req_byte   = ~b;
        bus.req_signed = ~s;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        for (int k = 1; k <= 10; k++) begin
            if (bus.mem_we) wem |= (1 << k);
            if (bus.mem_re) rem |= (1 << k);
            if (bus.req_ready) rdym |= (1 << k);
            if (k == 1) begin
                oaddr = bus.mem_address;
                owd   = bus.mem_write_data;
                obe   = bus.mem_be;
            end
            if (bus.resp_valid) begin
                nresp++;
                if (rk == 0) begin
                    rk   = k;
                    rdat = bus.resp_rdata;
                    rerr = bus.resp_error;
                end
            end
            if (bus.req_ready && rk != 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        checks++;
        if ({bus.resp_valid, bus.resp_error} !== 2'b00) begin
            errors++; $display("FAIL reset_resp: got %b want 00",
                               {bus.resp_valid, bus.resp_error});
        end
        checks++;
        if (bus.resp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata);
        end
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.mem_be} !== 3'b000 ||
            bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
            errors++; $display("FAIL reset_mem: got we/re/be %b addr %h wd %h want 0",
                               {bus.mem_we, bus.mem_re, bus.mem_be},
                               bus.mem_address, bus.mem_write_data);
        end
        rst = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        int rk, wem, rem, rdym, nr;
        logic [31:0] rd, oa, ow;
        logic re, ob;
        issue(1'b1, 1'b0, 1'b0, 32'h18, 32'hb6a84325, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        ref_store(1'b0, 32'h18, 32'hb6a84325);
        checks++;
        if (rk !== 2 || wem !== 2 || rem !== 0 || rdym !== 8) begin
            errors++; $display("FAIL word_store_timing: got rk %0d we %h re %h rdy %h want 2 2 0 8",
                               rk, wem, rem, rdym);
        end
        checks++;
        if (oa !== 32'h18 || ow !== 32'hb6a84325 || ob !== 1'b0) begin
            errors++; $display("FAIL word_store_bus: got %h %h %b want 18 b6a84325 0", oa, ow, ob);
        end
        issue(1'b0, 1'b0, 1'b0, 32'h18, 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rk !== 3 || rem !== 6 || wem !== 0 || rdym !== 16) begin
            errors++; $display("FAIL word_load_timing: got rk %0d re %h we %h rdy %h want 3 6 0 10",
                               rk, rem, wem, rdym);
        end
        checks++;
        if (rd !== 32'hb6a84325 || re !== 1'b0) begin
            errors++; $display("FAIL word_load_data: got %h err %b want b6a84325 0", rd, re);
        end
    endtask

    task automatic test_byte();
        int rk, wem, rem, rdym, nr;
        logic [31:0] rd, oa, ow;
        logic re, ob;
        issue(1'b1, 1'b1, 1'b0, 32'h19, 32'h55aa1374, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        ref_store(1'b1, 32'h19, 32'h55aa1374);
        checks++;
        if (ow !== 32'h00000074 || ob !== 1'b1 || oa !== 32'h19) begin
            errors++; $display("FAIL byte_store_bus: got wd %h be %b addr %h want 74 1 19", ow, ob, oa);
        end
        issue(1'b0, 1'b1, 1'b0, 32'h19, 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rd !== 32'h00000074) begin
            errors++; $display("FAIL byte_load_zext: got %h want 00000074", rd);
        end
        issue(1'b1, 1'b1, 1'b1, 32'h19, 32'habcdeff4, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        ref_store(1'b1, 32'h19, 32'habcdeff4);
        issue(1'b0, 1'b1, 1'b1, 32'h19, 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rd !== 32'hfffffff4) begin
            errors++; $display("FAIL byte_load_sext: got %h want fffffff4", rd);
        end
        issue(1'b0, 1'b1, 1'b0, 32'h19, 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rd !== 32'h000000f4) begin
            errors++; $display("FAIL byte_load_zext_hi: got %h want 000000f4", rd);
        end
        issue(1'b0, 1'b0, 1'b0, 32'h18, 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rd !== 32'hb6a8f425) begin
            errors++; $display("FAIL byte_merge_word: got %h want b6a8f425", rd);
        end
    endtask

    task automatic test_error();
        int rk, wem, rem, rdym, nr;
        logic [31:0] rd, oa, ow;
        logic re, ob;
        issue(1'b0, 1'b0, 1'b0, 32'h1a, 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rk !== 1 || re !== 1'b1 || rd !== 32'h0 || rdym !== 4) begin
            errors++; $display("FAIL misalign_load: got rk %0d err %b rd %h rdy %h want 1 1 0 4",
                               rk, re, rd, rdym);
        end
        checks++;
        if (wem !== 0 || rem !== 0) begin
            errors++; $display("FAIL misalign_strobe: got we %h re %h want 0 0", wem, rem);
        end
        issue(1'b1, 1'b0, 1'b0, 32'h1e, 32'hdeadbeef, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
        checks++;
        if (rk !== 1 || re !== 1'b1 || wem !== 0) begin
            errors++; $display("FAIL misalign_store: got rk %0d err %b we %h want 1 1 0", rk, re, wem);
        end
    endtask

    task automatic test_boundary();
        int rk, wem, rem, rdym, nr;
        logic [31:0] rd, oa, ow;
        logic re, ob;
        logic [31:0] ba [5];
        logic        bb [5];
        ba = '{32'h3ff, 32'h3fc, 32'h400, 32'h400, 32'h3fd};
        bb = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, bb[i], 1'b1, ba[i], 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
            checks++;
            if (re !== exp_fail(bb[i], ba[i]) ||
                rd !== (exp_fail(bb[i], ba[i]) ? 32'h0 : ref_load(bb[i], 1'b1, ba[i]))) begin
                errors++; $display("FAIL boundary_%h_b%0d: got err %b rd %h want err %b rd %h",
                                   ba[i], bb[i], re, rd, exp_fail(bb[i], ba[i]),
                                   exp_fail(bb[i], ba[i]) ? 32'h0 : ref_load(bb[i], 1'b1, ba[i]));
            end
        end
    endtask

    task automatic test_random();
        int rk, wem, rem, rdym, nr, ek;
        logic [31:0] rd, oa, ow, a, d, er;
        logic re, ob, w, b, s, f;
        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom);
            b = 1'($urandom);
            s = 1'($urandom);
            a = $urandom_range(0, 1040);
            if (!b && ($urandom % 4 != 0)) a[1:0] = 2'b00;
            d = $urandom;
            f = exp_fail(b, a);
            ek = f ? 1 : (w ? 2 : 3);
            er = (f || w) ? 32'h0 : ref_load(b, s, a);
            issue(w, b, s, a, d, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
            if (!f && w) ref_store(b, a, d);
            checks++;
            if (rk !== ek || nr !== 1 || rdym !== (1 << (ek + 1))) begin
                errors++; $display("FAIL rand_timing[%0d]: got rk %0d n %0d rdy %h want %0d 1 %h",
                                   n, rk, nr, rdym, ek, 1 << (ek + 1));
            end
            checks++;
            if (re !== f || rd !== er) begin
                errors++; $display("FAIL rand_resp[%0d]: got err %b rd %h want %b %h",
                                   n, re, rd, f, er);
            end
            checks++;
            if (wem !== ((!f && w) ? 2 : 0) || rem !== ((!f && !w) ? 6 : 0)) begin
                errors++; $display("FAIL rand_strobe[%0d]: got we %h re %h want %h %h",
                                   n, wem, rem, (!f && w) ? 2 : 0, (!f && !w) ? 6 : 0);
            end
            if (!f) begin
                checks++;
                if (oa !== a || ob !== b ||
                    ow !== (w ? (b ? {24'h0, d[7:0]} : d) : 32'h0)) begin
                    errors++; $display("FAIL rand_bus[%0d]: got addr %h be %b wd %h want %h %b",
                                       n, oa, ob, ow, a, b);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int rk, wem, rem, rdym, nr, nwe;
        logic [31:0] rd, oa, ow;
        logic re, ob;
        logic [31:0] acc [$];
        nwe = 0;
        for (int c = 0; c < 12; c++) begin
            bus.req_valid  = 1'b1;
            bus.req_write  = 1'b1;
            bus.req_byte   = 1'b0;
            bus.req_signed = 1'b0;
            bus.req_addr   = {22'h0, 8'($urandom), 2'b00};
            bus.req_wdata  = $urandom;
            checks++;
            if (bus.req_ready !== (c % 3 == 0)) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want %b",
                                   c, bus.req_ready, c % 3 == 0);
            end
            checks++;
            if (bus.mem_we !== (c % 3 == 1)) begin
                errors++; $display("FAIL b2b_we[%0d]: got %b want %b", c, bus.mem_we, c % 3 == 1);
            end
            if (bus.mem_we) nwe++;
            if (c % 3 == 0) begin
                ref_store(1'b0, bus.req_addr, bus.req_wdata);
                acc.push_back(bus.req_addr);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (nwe !== 4) begin
            errors++; $display("FAIL b2b_we_count: got %0d want 4", nwe);
        end
        foreach (acc[i]) begin
            issue(1'b0, 1'b0, 1'b0, acc[i], 32'h0, rk, rd, re, wem, rem, rdym, nr, oa, ow, ob);
            checks++;
            if (rd !== ref_load(1'b0, 1'b0, acc[i])) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h want %h",
                                   i, rd, ref_load(1'b0, 1'b0, acc[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h20;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_re !== 1'b1) begin
            errors++; $display("FAIL mid_capture_re: got %b want 1", bus.mem_re);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_re !== 1'b0 || bus.resp_valid !== 1'b0 || bus.mem_address !== 32'h0) begin
            errors++; $display("FAIL mid_reset_async: got re %b rv %b addr %h want 0 0 0",
                               bus.mem_re, bus.resp_valid, bus.mem_address);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ready: got %b want 1", bus.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid || !bus.req_ready || bus.mem_re) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37) ^ 8'h5A;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        test_reset();
        test_word();
        test_byte();
        test_error();
        test_boundary();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
